dco_acq_ctrl: RTL

- Frequency-acquisition sequencer for the ADPLL DCO. Runs two successive-approximation (SAR) searches against a target count: first the coarse tuning word (CTW), then the fine tuning word (FTW).
- Each trial pulses an external DCO edge counter and compares the returned count with the target.
- On completion, holds the final CTW/FTW, asserts locked, and hands the DCO over to the tracking loop.

---
 rtl/dco_acq_if.sv | 30 +++
 rtl/dco_acq_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dco_acq_if.sv
// DCO acquisition bundle: control/target inputs, measurement handshake and tuning words.
// master = acquisition controller, slave = DCO/counter/host side.
interface dco_acq_if #(
  parameter int CTW_W = 8,
  parameter int FTW_W = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] fcw;
  logic [CNT_W-1:0] meas_count;
  logic             meas_valid;
  logic [CTW_W-1:0] CTW;
  logic [FTW_W-1:0] FTW;
  logic             dco_enable;
  logic             meas_start;
  logic             busy;
  logic             locked;
  logic             error;

  modport master (
    input  start, abort, fcw, meas_count, meas_valid,
    output CTW, FTW, dco_enable, meas_start, busy, locked, error
  );

  modport slave (
    output start, abort, fcw, meas_count, meas_valid,
    input  CTW, FTW, dco_enable, meas_start, busy, locked, error
  );
endinterface

// File: rtl/dco_acq_ctrl.sv
// Two-pass SAR acquisition (coarse CTW, then fine FTW) against a captured target count.
// All outputs registered; each bit waits on meas_valid, bounded by TIMEOUT_CYCLES.
module dco_acq_ctrl #(
  parameter int CTW_W          = 8,
  parameter int FTW_W          = 8,
  parameter int CNT_W          = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic      clk_ref,
  input  logic      rst,
  dco_acq_if.master acq
);

  localparam int K_MAX = (CTW_W > FTW_W) ? CTW_W : FTW_W;
  localparam int K_W   = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int S_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int T_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FTW_W-1:0] FTW_MID = FTW_W'(1) << (FTW_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIAL, S_SETTLE, S_MEAS, S_LOCKED, S_ERROR
  } state_t;

  typedef enum logic {PH_COARSE, PH_FINE} phase_t;

  state_t           state_q, nxt_state;
  phase_t           phase_q, nxt_phase;
  logic [K_W-1:0]   k_q, nxt_k;
  logic [S_W-1:0]   set_q, nxt_set;
  logic [T_W-1:0]   tmo_q, nxt_tmo;
  logic [CNT_W-1:0] fcw_q, nxt_fcw;
  logic [CTW_W-1:0] ctw_q, nxt_ctw;
  logic [FTW_W-1:0] ftw_q, nxt_ftw;
  logic             en_q, nxt_en;
  logic             ms_q, nxt_ms;
  logic             busy_q, nxt_busy;
  logic             locked_q, nxt_locked;
  logic             err_q, nxt_err;

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_COARSE;
      k_q      <= '0;
      set_q    <= '0;
      tmo_q    <= '0;
      fcw_q    <= '0;
      ctw_q    <= '0;
      ftw_q    <= FTW_MID;
      en_q     <= 1'b0;
      ms_q     <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= nxt_state;
      phase_q  <= nxt_phase;
      k_q      <= nxt_k;
      set_q    <= nxt_set;
      tmo_q    <= nxt_tmo;
      fcw_q    <= nxt_fcw;
      ctw_q    <= nxt_ctw;
      ftw_q    <= nxt_ftw;
      en_q     <= nxt_en;
      ms_q     <= nxt_ms;
      busy_q   <= nxt_busy;
      locked_q <= nxt_locked;
      err_q    <= nxt_err;
    end
  end

  always_comb begin
    nxt_state  = state_q;
    nxt_phase  = phase_q;
    nxt_k      = k_q;
    nxt_set    = set_q;
    nxt_tmo    = tmo_q;
    nxt_fcw    = fcw_q;
    nxt_ctw    = ctw_q;
    nxt_ftw    = ftw_q;
    nxt_en     = en_q;
    nxt_ms     = 1'b0;
    nxt_busy   = busy_q;
    nxt_locked = locked_q;
    nxt_err    = err_q;

    if (acq.abort) begin
      // Abort overrides everything, including start, but leaves the words in place.
      nxt_state  = S_IDLE;
      nxt_en     = 1'b0;
      nxt_busy   = 1'b0;
      nxt_locked = 1'b0;
      nxt_err    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_LOCKED, S_ERROR: begin
          if (acq.start) begin
            nxt_fcw    = acq.fcw;
            nxt_ctw    = '0;
            nxt_ftw    = FTW_MID;
            nxt_en     = 1'b1;
            nxt_busy   = 1'b1;
            nxt_locked = 1'b0;
            nxt_err    = 1'b0;
            nxt_phase  = PH_COARSE;
            nxt_k      = K_W'(CTW_W - 1);
            nxt_state  = S_TRIAL;
          end
        end
        S_TRIAL: begin
          if (phase_q == PH_COARSE) nxt_ctw[k_q] = 1'b1;
          else                      nxt_ftw[k_q] = 1'b1;
          nxt_set   = '0;
          nxt_state = S_SETTLE;
        end
        S_SETTLE: begin
          if (set_q == S_W'(SETTLE_CYCLES - 1)) begin
            nxt_ms    = 1'b1;
            nxt_tmo   = '0;
            nxt_state = S_MEAS;
          end else begin
            nxt_set = set_q + S_W'(1);
          end
        end
        S_MEAS: begin
          if (acq.meas_valid) begin
            // Too fast: drop the trial bit. Equal counts keep it.
            if (acq.meas_count > fcw_q) begin
              if (phase_q == PH_COARSE) nxt_ctw[k_q] = 1'b0;
              else                      nxt_ftw[k_q] = 1'b0;
            end
            if (k_q != '0) begin
              nxt_k     = k_q - K_W'(1);
              nxt_state = S_TRIAL;
            end else if (phase_q == PH_COARSE) begin
              nxt_phase = PH_FINE;
              nxt_ftw   = '0;
              nxt_k     = K_W'(FTW_W - 1);
              nxt_state = S_TRIAL;
            end else begin
              nxt_busy   = 1'b0;
              nxt_locked = 1'b1;
              nxt_state  = S_LOCKED;
            end
          end else if (tmo_q == T_W'(TIMEOUT_CYCLES - 1)) begin
            nxt_busy  = 1'b0;
            nxt_err   = 1'b1;
            nxt_en    = 1'b0;
            nxt_state = S_ERROR;
          end else begin
            nxt_tmo = tmo_q + T_W'(1);
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  assign acq.CTW        = ctw_q;
  assign acq.FTW        = ftw_q;
  assign acq.dco_enable = en_q;
  assign acq.meas_start = ms_q;
  assign acq.busy       = busy_q;
  assign acq.locked     = locked_q;
  assign acq.error      = err_q;

endmodule
